// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-requester ALU scheduler: FSM states,
// ALU opcode values and the default watchdog length.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Cycles allowed in WAIT before the operation is aborted with an error.
  localparam int DEFAULT_TIMEOUT = 32;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. Purely combinational; the caller owns the
// last_grant history and decides when it advances.
module rr_arbiter2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Lone requester wins outright; on contention the one not served last wins.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU control unit between two requesters: round-robin accept,
// one-cycle start pulse, watchdog-guarded wait for done, tagged response.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_opcode0,
  input  logic [1:0]  req_opcode1,
  input  logic [7:0]  req_a0,
  input  logic [7:0]  req_b0,
  input  logic [7:0]  req_a1,
  input  logic [7:0]  req_b1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        alu_start,
  output logic [1:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy
);

  // Last WAIT count at which a missing done turns into a timeout.
  localparam logic [7:0] TERM_CNT = 8'(TIMEOUT - 1);

  sched_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         last_grant_q, last_grant_d;
  logic         id_q, id_d;
  logic [1:0]   op_q, op_d;
  logic [7:0]   a_q, a_d;
  logic [7:0]   b_q, b_d;
  logic [15:0]  data_q, data_d;
  logic         err_q, err_d;

  logic [1:0]   grant;
  logic [1:0]   hs;
  logic         term;

  rr_arbiter2 u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign hs   = req_valid & req_ready;
  assign term = (cnt_q == TERM_CNT);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done on the terminal count still counts as success.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|hs) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (alu_done || term) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    req_ready = 2'b00;
    alu_start = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:  req_ready = grant & req_valid;
      ST_ISSUE: alu_start = 1'b1;
      ST_RESP:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  // Request capture, watchdog count, result capture and grant history.
  always_comb begin
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    data_d       = data_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (|hs) begin
          id_d = hs[1];
          op_d = hs[1] ? req_opcode1 : req_opcode0;
          a_d  = hs[1] ? req_a1      : req_a0;
          b_d  = hs[1] ? req_b1      : req_b0;
        end
      end
      ST_ISSUE: cnt_d = 8'd0;
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (alu_done) begin
          data_d = alu_result;
          err_d  = 1'b0;
        end else if (term) begin
          data_d = 16'h0000;
          err_d  = 1'b1;
        end
      end
      ST_RESP: if (rsp_ready) last_grant_d = id_q;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= 8'd0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= 2'b00;
      a_q          <= 8'h00;
      b_q          <= 8'h00;
      data_q       <= 16'h0000;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_err    = err_q;
  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler: a behavioural ALU answers start
// pulses, an accept monitor queues the hand-computed expected response,
// and a response monitor pops and compares on every response handshake.
module tb_alu_op_scheduler;
  import alu_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_opcode0 = 2'b00, req_opcode1 = 2'b00;
  logic [7:0]  req_a0 = 8'h00, req_b0 = 8'h00, req_a1 = 8'h00, req_b1 = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        alu_start;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0000;
  logic        busy;

  alu_op_scheduler #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode0(req_opcode0), .req_opcode1(req_opcode1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miscmp = 0;
  int start_cnt = 0;
  int acc_cnt = 0;
  logic [17:0] sb[$];
  int gl[$];
  logic [15:0] exp_d [2];
  logic        exp_e [2];
  logic        no_rsp = 1'b0;

  // ALU behaviour knobs
  logic alu_en = 1'b1;
  logic spur = 1'b0;
  int   dly = 2;
  logic [1:0] m_op;
  logic [7:0] m_a, m_b;
  logic [17:0] m_e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    vec++;
    miscmp++;
    $display("FAIL %s: cycle budget expired", nm);
  endtask

  function automatic logic [15:0] alu_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r8;
    case (op)
      OP_ADD: begin r8 = a + b; return {8'h00, r8}; end
      OP_SUB: begin r8 = a - b; return {8'h00, r8}; end
      OP_MUL: return 16'(a) * 16'(b);
      default: return {a % b, a / b};
    endcase
  endfunction

  // Behavioural ALU: optional spurious done during ISSUE, real done dly cycles after start.
  always begin
    @(negedge clk);
    if (alu_start) begin
      m_op = alu_opcode; m_a = alu_a; m_b = alu_b;
      if (spur) begin alu_done = 1'b1; alu_result = 16'hDEAD; end
      if (alu_en) begin
        repeat (dly) begin @(posedge clk); #1; alu_done = 1'b0; end
        alu_done = 1'b1;
        alu_result = alu_model(m_op, m_a, m_b);
        @(posedge clk); #1;
        alu_done = 1'b0;
      end else begin
        @(posedge clk); #1;
        alu_done = 1'b0;
      end
    end
  end

  // Start pulse counter.
  always begin
    @(negedge clk);
    if (alu_start) start_cnt++;
  end

  // Accept monitor: log grant and queue the expected response.
  always begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset && req_valid[i] && req_ready[i]) begin
        gl.push_back(i);
        acc_cnt++;
        if (!no_rsp) sb.push_back({i[0], exp_e[i], exp_d[i]});
      end
    end
  end

  // Response monitor: compare on every response handshake.
  always begin
    @(negedge clk);
    if (reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        vec++;
        miscmp++;
        $display("FAIL unexpected_rsp: got id=%0d data=%0h err=%0d want none", rsp_id, rsp_data, rsp_err);
      end else begin
        m_e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(m_e[17]));
        check("rsp_err", 32'(rsp_err), 32'(m_e[16]));
        check("rsp_data", 32'(rsp_data), 32'(m_e[15:0]));
      end
    end
  end

  task automatic issue(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] ed, input logic ee);
    bit ok = 0;
    exp_d[id] = ed;
    exp_e[id] = ee;
    if (id == 0) begin req_opcode0 = op; req_a0 = a; req_b0 = b; end
    else         begin req_opcode1 = op; req_a1 = a; req_b1 = b; end
    req_valid[id] = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (req_ready[id]) begin ok = 1; break; end
    end
    if (!ok) bound_fail("accept_wait");
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) bound_fail("idle_wait");
    @(posedge clk); #1;
  endtask

  task automatic contend(input int n_acc);
    int base;
    bit ok = 0;
    base = acc_cnt;
    req_opcode0 = OP_MUL; req_a0 = 8'h0F; req_b0 = 8'h03;
    req_opcode1 = OP_SUB; req_a1 = 8'h10; req_b1 = 8'h01;
    exp_d[0] = 16'h002D; exp_e[0] = 1'b0;
    exp_d[1] = 16'h000F; exp_e[1] = 1'b0;
    req_valid = 2'b11;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #2;
      if (acc_cnt >= base + n_acc) begin ok = 1; break; end
    end
    if (!ok) bound_fail("contention_wait");
    req_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g0, k, s0, hi;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_alu_start", 32'(alu_start), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_id_err", 32'({rsp_id, rsp_err}), 0);
    check("rst_alu_regs", 32'({alu_opcode, alu_a, alu_b}), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Contention: grants alternate starting with requester 0
    g0 = gl.size();
    contend(4);
    wait_idle();
    if (gl.size() >= g0 + 4) begin
      check("grant0", 32'(gl[g0]), 0);
      check("grant1", 32'(gl[g0+1]), 1);
      check("grant2", 32'(gl[g0+2]), 0);
      check("grant3", 32'(gl[g0+3]), 1);
    end else bound_fail("grant_log");

    // Single ADD on requester 0, latency and start pulse
    s0 = start_cnt;
    dly = 2;
    issue(0, OP_ADD, 8'h12, 8'h34, 16'h0046, 1'b0);
    @(negedge clk);
    check("issue_start", 32'(alu_start), 1);
    check("issue_regs", 32'({alu_opcode, alu_a, alu_b}), 32'({OP_ADD, 8'h12, 8'h34}));
    @(negedge clk);
    check("wait_start_low", 32'(alu_start), 0);
    @(negedge clk);
    check("rsp_not_yet", 32'(rsp_valid), 0);
    @(negedge clk);
    check("rsp_at_t4", 32'(rsp_valid), 1);
    wait_idle();
    check("start_once", 32'(start_cnt - s0), 1);

    // Backpressure on requester 1 SUB 5-7, requester 0 waits meanwhile
    rsp_ready = 1'b0;
    issue(1, OP_SUB, 8'h05, 8'h07, 16'h00FE, 1'b0);
    k = 0;
    while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    exp_d[0] = 16'h0002; exp_e[0] = 1'b0;
    req_opcode0 = OP_ADD; req_a0 = 8'h01; req_b0 = 8'h01;
    req_valid[0] = 1'b1;
    s0 = start_cnt;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("bp_hold", 32'({rsp_valid, rsp_id, rsp_err, rsp_data, req_ready}),
            32'({1'b1, 1'b1, 1'b0, 16'h00FE, 2'b00}));
    end
    check("bp_no_start", 32'(start_cnt - s0), 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hs_cycle_no_accept", 32'(req_ready), 0);
    @(negedge clk);
    check("post_hs_idle", 32'({busy, req_ready}), 32'({1'b0, 2'b01}));
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_idle();

    // Spurious done during ISSUE is ignored: DIV 100/7 -> rem 2, quot 14
    spur = 1'b1;
    dly = 3;
    issue(0, OP_DIV, 8'h64, 8'h07, 16'h020E, 1'b0);
    spur = 1'b0;
    wait_idle();

    // Watchdog timeout: response with error exactly 10 cycles after accept
    alu_en = 1'b0;
    issue(1, OP_ADD, 8'h01, 8'h02, 16'h0000, 1'b1);
    k = 1;
    @(negedge clk);
    while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
    check("timeout_latency", 32'(k), 10);
    wait_idle();

    // Done on the terminal count wins
    alu_en = 1'b1;
    dly = 8;
    issue(0, OP_ADD, 8'h03, 8'h04, 16'h0007, 1'b0);
    k = 1;
    @(negedge clk);
    while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
    check("terminal_latency", 32'(k), 10);
    wait_idle();

    // Reset mid-WAIT: outputs clear, no response, grant history restored
    alu_en = 1'b0;
    no_rsp = 1'b1;
    issue(1, OP_MUL, 8'h02, 8'h02, 16'h0004, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_outputs", 32'({busy, rsp_valid, alu_start, req_ready, rsp_err, rsp_id}), 0);
    check("midrst_regs", 32'({alu_opcode, alu_a, alu_b}), 0);
    check("midrst_data", 32'(rsp_data), 0);
    no_rsp = 1'b0;
    hi = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (rsp_valid) hi++;
    end
    check("midrst_no_rsp", 32'(hi), 0);
    @(posedge clk); #1;
    alu_en = 1'b1;
    dly = 2;
    g0 = gl.size();
    contend(1);
    wait_idle();
    if (gl.size() > g0) check("post_rst_grant", 32'(gl[g0]), 0);
    else bound_fail("post_rst_grant_log");

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
# alu_op_scheduler

Sequences and shares the 8-bit ALU (ADD/SUB/Booth MUL/DIV control unit plus datapath) between two requesters. Accepts one operation at a time through a valid/ready request port per requester, arbitrates round-robin, and pulses the ALU `start`. It then waits for `done` under a watchdog and returns the result on a shared response channel tagged with the requester id. It sits between the two client blocks and the ALU control unit.

## Interface
- `TIMEOUT`, default 32: max cycles spent in WAIT before aborting with error (legal range 4..255).
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-low; sampled on rising edge of `clk`.
- `req_valid` input 2: per-requester request valid (bit i = requester i).
- `req_ready` output 2: per-requester accept; at most one bit high.
- `req_opcode0`, `req_opcode1` input 2 each: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` input 8 each: operands.
- `rsp_valid` output 1: response valid, held until accepted.
- `rsp_ready` input 1: response accept.
- `rsp_id` output 1: requester that owns the response.
- `rsp_data` output 16: ALU result (MUL full 16 bits; others as delivered by ALU).
- `rsp_err` output 1: 1 = watchdog timeout, `rsp_data` forced to 0.
- `alu_start` output 1: one-cycle start pulse to control unit.
- `alu_opcode` output 2; `alu_a`, `alu_b` output 8 each: held stable from ISSUE through WAIT.
- `alu_done` input 1; `alu_result` input 16.
- `busy` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready` raised combinationally for the granted requester only when its `req_valid` is high. Grant: only one valid -> that one; both valid -> the one not served last. `last_grant` resets to 1, so requester 0 wins first contention. Handshake (`req_valid & req_ready`) latches id, opcode, operands -> ISSUE.
- ISSUE: `alu_start`=1 for exactly this cycle; watchdog counter cleared -> WAIT. `alu_done` here is ignored.
- WAIT: counter increments each cycle. `alu_done`=1 -> latch `alu_result` into `rsp_data`, `rsp_err`=0 -> RESP. Counter reaching TIMEOUT-1 without `alu_done` -> `rsp_data`=0, `rsp_err`=1 -> RESP. `alu_done` on the terminal count cycle wins (no error).
- RESP: `rsp_valid`=1 with stable `rsp_id`/`rsp_data`/`rsp_err` until `rsp_ready`. The handshake cycle updates `last_grant` to `rsp_id` -> IDLE. No new request is accepted in the handshake cycle; earliest next accept is the following cycle.
- `last_grant` updates only on response handshake; a timed-out operation still counts as served.
- `alu_opcode`/`alu_a`/`alu_b` are registered; they change only on request accept.

## Timing
- Reset (`reset`=0 at edge): state IDLE, `req_ready`=0 registered state terms, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0, `alu_start`=0, `alu_opcode`/`alu_a`/`alu_b`=0, `busy`=0, counter 0, `last_grant`=1. Reset mid-operation aborts with no response; `alu_start` is low from the reset edge on.
- Latency: accept at cycle T, `alu_start` at T+1, first `alu_done` sample at T+2. `rsp_valid` is one cycle after the `alu_done` sample. Minimum accept-to-`rsp_valid` is 3 cycles.
- Timeout: `rsp_valid` with `rsp_err` rises at T+2+TIMEOUT when `alu_done` never arrives.
- Requests may drop `req_valid` before accept without effect; operands are sampled only at the accept edge.

## Structure
- Shared package `alu_sched_pkg`: state encoding (IDLE, ISSUE, WAIT, RESP), opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV, and the default TIMEOUT.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin grant from `req_valid` and `last_grant`, instantiated by the FSM.

## Test plan
- Single request 0: ADD a=0x12 b=0x34, `alu_done` 2 cycles after `alu_start`, `alu_result`=0x0046 -> `rsp_valid` with `rsp_id`=0, `rsp_data`=0x0046, `rsp_err`=0; `alu_start` pulsed once.
- Contention: both valid continuously, MUL 0x0F*0x03 and SUB 0x10-0x01 -> grants alternate 0,1,0,1. The first response has `rsp_id`=0 and `rsp_data`=0x002D as returned by the ALU model.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP -> outputs stable, `req_ready`=0 for both, no `alu_start`; release -> one handshake, then IDLE.
- Timeout with TIMEOUT=8 and `alu_done` never asserted -> `rsp_err`=1, `rsp_data`=0 exactly 10 cycles after accept. `alu_done` at the terminal count -> `rsp_err`=0.
- Spurious done: `alu_done`=1 during ISSUE then real done later -> only the later `alu_result` is returned.
- Reset mid-WAIT (`reset`=0 one cycle) -> all outputs 0 next cycle, no response. The next contended request is granted to requester 0.
